// File: rtl/stages_definition_pkg.sv
// -----------------------------------------------------------------------------
// stages_definition_pkg
//   Shared definitions for the pixel memory arbiter.
//   pix_arb_state_e : arbiter FSM state encoding
//   PIX_MEM_RD_LAT  : pixel RAM read latency in cycles (data after enable)
// -----------------------------------------------------------------------------
package stages_definition_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CPU_ISSUE = 3'd1,
    ST_CPU_WAIT  = 3'd2,
    ST_DISP      = 3'd3,
    ST_DISP_WAIT = 3'd4
  } pix_arb_state_e;

  localparam int PIX_MEM_RD_LAT = 1;

endpackage

// File: rtl/pix_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// pix_burst_addr_gen
//   Address generator for display read bursts. Latches the burst base on
//   load, counts reads on step and reports the address of the read after
//   the current one (wrapping modulo 2^ADDR_W) plus a last-read flag.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   start a burst: latch base, counter to 0
//   step       in   advance to the next read of the burst
//   base       in   burst start address
//   next_addr  out  base + cnt + 1 (address of the following read)
//   last       out  current read is the final one of the burst
// -----------------------------------------------------------------------------
module pix_burst_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);

  localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      base_reg <= base;
      cnt_reg  <= '0;
    end else if (step) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Truncation to ADDR_W bits gives the required wrap past the top address.
  assign next_addr = base_reg + ADDR_W'(cnt_reg) + ADDR_W'(1);
  assign last      = (cnt_reg == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/pix_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pix_mem_arbiter
//   Shares a single-port pixel RAM between CPU single accesses (stalling the
//   pipeline until done) and fixed-length display read bursts.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU access request (held while stalled)
//   cpu_stall_o                   access not yet complete
//   cpu_rvalid_o/cpu_rdata_o      read data, one cycle
//   disp_req_i/disp_base_i        display burst request and start address
//   disp_gnt_o                    burst accepted (combinational pulse)
//   disp_rvalid_o/disp_rdata_o    burst read data
//   disp_done_o                   pulses with the last burst rvalid
//   mem_en_o/we_o/addr_o/wdata_o  registered RAM controls
//   mem_rdata_i                   RAM read data, one cycle after enable
//   cpu_wait_cnt_o                (PIX_ARB_STATS_EN only) saturating count of
//                                 CPU stall cycles spent behind a burst
// Configuration macro: PIX_ARB_STATS_EN
// -----------------------------------------------------------------------------
module pix_mem_arbiter
  import stages_definition_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_base_i,
  output logic              disp_gnt_o,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef PIX_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_wait_cnt_o
`endif
);

  pix_arb_state_e            state_reg;
  logic                      fair_reg;
  logic                      cpu_we_reg;
  logic                      mem_en_reg;
  logic                      mem_we_reg;
  logic [ADDR_W-1:0]         mem_addr_reg;
  logic [DATA_W-1:0]         mem_wdata_reg;
  logic [PIX_MEM_RD_LAT-1:0] disp_rv_pipe_reg;
  logic [PIX_MEM_RD_LAT-1:0] disp_done_pipe_reg;

  logic              disp_win;
  logic              cpu_issue;
  logic              burst_step;
  logic              burst_last;
  logic [ADDR_W-1:0] burst_next_addr;

  // Display wins a tie unless the previous burst left the fair flag set.
  assign disp_win = (state_reg == ST_IDLE) && disp_req_i && !(cpu_req_i && fair_reg);

  // DISP_WAIT hands the RAM straight to a waiting CPU: the fair flag is being
  // set there anyway, so the IDLE decision would be the same one cycle later.
  assign cpu_issue = cpu_req_i &&
                     (((state_reg == ST_IDLE) && !disp_win) || (state_reg == ST_DISP_WAIT));

  assign burst_step = (state_reg == ST_DISP) && !burst_last;

  pix_burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (disp_win),
    .step      (burst_step),
    .base      (disp_base_i),
    .next_addr (burst_next_addr),
    .last      (burst_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      fair_reg           <= 1'b0;
      cpu_we_reg         <= 1'b0;
      mem_en_reg         <= 1'b0;
      mem_we_reg         <= 1'b0;
      mem_addr_reg       <= '0;
      mem_wdata_reg      <= '0;
      disp_rv_pipe_reg   <= '0;
      disp_done_pipe_reg <= '0;
    end else begin
      mem_en_reg <= 1'b0;
      mem_we_reg <= 1'b0;

      // The RAM read on the bus during DISP returns PIX_MEM_RD_LAT cycles later.
      disp_rv_pipe_reg[0]   <= (state_reg == ST_DISP);
      disp_done_pipe_reg[0] <= (state_reg == ST_DISP) && burst_last;
      for (int i = 1; i < PIX_MEM_RD_LAT; i++) begin
        disp_rv_pipe_reg[i]   <= disp_rv_pipe_reg[i-1];
        disp_done_pipe_reg[i] <= disp_done_pipe_reg[i-1];
      end

      case (state_reg)
        ST_IDLE: begin
          if (disp_win) begin
            state_reg    <= ST_DISP;
            mem_en_reg   <= 1'b1;
            mem_addr_reg <= disp_base_i;
          end else if (cpu_req_i) begin
            state_reg <= ST_CPU_ISSUE;
          end
        end
        ST_CPU_ISSUE: state_reg <= ST_CPU_WAIT;
        ST_CPU_WAIT: begin
          fair_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_DISP: begin
          if (burst_last) begin
            state_reg <= ST_DISP_WAIT;
          end else begin
            mem_en_reg   <= 1'b1;
            mem_addr_reg <= burst_next_addr;
          end
        end
        ST_DISP_WAIT: begin
          fair_reg <= 1'b1;
          if (cpu_req_i) state_reg <= ST_CPU_ISSUE;
          else           state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (cpu_issue) begin
        mem_en_reg    <= 1'b1;
        mem_we_reg    <= cpu_we_i;
        mem_addr_reg  <= cpu_addr_i;
        mem_wdata_reg <= cpu_wdata_i;
        cpu_we_reg    <= cpu_we_i;
      end
    end
  end

  assign mem_en_o    = mem_en_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;

  assign cpu_stall_o   = cpu_req_i && (state_reg != ST_CPU_WAIT);
  assign cpu_rvalid_o  = (state_reg == ST_CPU_WAIT) && !cpu_we_reg;
  assign cpu_rdata_o   = cpu_rvalid_o ? mem_rdata_i : '0;

  assign disp_gnt_o    = disp_win;
  assign disp_rvalid_o = disp_rv_pipe_reg[PIX_MEM_RD_LAT-1];
  assign disp_rdata_o  = disp_rvalid_o ? mem_rdata_i : '0;
  assign disp_done_o   = disp_done_pipe_reg[PIX_MEM_RD_LAT-1];

`ifdef PIX_ARB_STATS_EN
  logic [15:0] wait_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (cpu_stall_o && ((state_reg == ST_DISP) || (state_reg == ST_DISP_WAIT)) &&
                 (wait_cnt_reg != 16'hFFFF)) begin
      wait_cnt_reg <= wait_cnt_reg + 16'd1;
    end
  end

  assign cpu_wait_cnt_o = wait_cnt_reg;
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_pix_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pix_mem_arbiter
//   Directed bench for pix_mem_arbiter with a behavioural pixel RAM
//   (1-cycle registered read, pre-loaded with a known pattern).
// -----------------------------------------------------------------------------
module tb_pix_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_stall_o;
  logic        cpu_rvalid_o;
  logic [7:0]  cpu_rdata_o;
  logic        disp_req;
  logic [15:0] disp_base;
  logic        disp_gnt_o;
  logic        disp_rvalid_o;
  logic [7:0]  disp_rdata_o;
  logic        disp_done_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata;
`ifdef PIX_ARB_STATS_EN
  logic [15:0] cpu_wait_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pix_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_LEN(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_i     (cpu_req),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_stall_o   (cpu_stall_o),
    .cpu_rvalid_o  (cpu_rvalid_o),
    .cpu_rdata_o   (cpu_rdata_o),
    .disp_req_i    (disp_req),
    .disp_base_i   (disp_base),
    .disp_gnt_o    (disp_gnt_o),
    .disp_rvalid_o (disp_rvalid_o),
    .disp_rdata_o  (disp_rdata_o),
    .disp_done_o   (disp_done_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata)
`ifdef PIX_ARB_STATS_EN
    ,
    .cpu_wait_cnt_o (cpu_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM model: read-first, one cycle latency.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      mem_rdata <= ram[mem_addr_o];
    end
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  logic [46:0] all_outs;
  assign all_outs = {cpu_stall_o, cpu_rvalid_o, cpu_rdata_o, disp_gnt_o, disp_rvalid_o,
                     disp_rdata_o, disp_done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};

  // Capture storage, filled by capture().
  logic [15:0] rd_addr [0:63];
  int          rd_cyc  [0:63];
  logic [7:0]  rv_data [0:63];
  int          rv_cyc  [0:63];
  int n_rd, n_rv, n_done, done_cyc, n_gnt, gnt_cyc0, n_stall, n_cpu_rv, cpu_rv_cyc;
  logic [7:0] cpu_rv_data;

  // Observes ncyc cycles starting at the current negedge; cycle 0 is the
  // cycle in which the requests were just applied.
  task automatic capture(input int ncyc, input bit keep_disp);
    bit rel;
    n_rd = 0; n_rv = 0; n_done = 0; done_cyc = -1; n_gnt = 0; gnt_cyc0 = -1;
    n_stall = 0; n_cpu_rv = 0; cpu_rv_cyc = -1; cpu_rv_data = '0;
    for (int c = 0; c < ncyc; c++) begin
      rel = 1'b0;
      #1;
      if (mem_en_o && !mem_we_o && n_rd < 64) begin
        rd_addr[n_rd] = mem_addr_o; rd_cyc[n_rd] = c; n_rd++;
      end
      if (disp_rvalid_o && n_rv < 64) begin
        rv_data[n_rv] = disp_rdata_o; rv_cyc[n_rv] = c; n_rv++;
      end
      if (disp_done_o) begin
        if (n_done == 0) done_cyc = c;
        n_done++;
      end
      if (disp_gnt_o) begin
        if (n_gnt == 0) gnt_cyc0 = c;
        n_gnt++;
      end
      if (cpu_stall_o) n_stall++;
      if (cpu_rvalid_o) begin
        cpu_rv_cyc = c; cpu_rv_data = cpu_rdata_o; n_cpu_rv++;
      end
      if (cpu_req && !cpu_stall_o) rel = 1'b1;
      @(negedge clk);
      if (!keep_disp) disp_req = 1'b0;
      if (rel) cpu_req = 1'b0;
    end
  endtask

  // Performs one CPU access starting at a negedge; returns after the
  // release cycle with the request dropped.
  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                            output int stalls, output int wes, output int rvs,
                            output logic [7:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    stalls = 0; wes = 0; rvs = 0; rd = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (mem_en_o && mem_we_o) wes++;
      if (cpu_rvalid_o) begin rvs++; rd = cpu_rdata_o; end
      if (!cpu_stall_o) break;
      stalls++;
      @(negedge clk);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (all_outs !== 47'd0) $display("FAIL reset_outs: got %h required 0", all_outs);
    else n_pass++;
`ifdef PIX_ARB_STATS_EN
    n_checks++;
    if (cpu_wait_cnt !== 16'd0) $display("FAIL reset_wait_cnt: got %0d required 0", cpu_wait_cnt);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (all_outs !== 47'd0) $display("FAIL idle_outs: got %h required 0", all_outs);
    else n_pass++;
    @(negedge clk);
    $display("reset: outputs %h", all_outs);
  endtask

  task automatic test_cpu_write_read();
    int stalls, wes, rvs;
    logic [7:0] rd;
    cpu_access(1'b1, 16'h0010, 8'hA5, stalls, wes, rvs, rd);
    $display("cpu write addr 0010 data a5: stalls %0d writes %0d rvalids %0d", stalls, wes, rvs);
    n_checks++;
    if (stalls !== 2) $display("FAIL wr_stall: got %0d required 2", stalls); else n_pass++;
    n_checks++;
    if (wes !== 1) $display("FAIL wr_mem_we: got %0d required 1", wes); else n_pass++;
    n_checks++;
    if (rvs !== 0) $display("FAIL wr_rvalid: got %0d required 0", rvs); else n_pass++;

    cpu_access(1'b0, 16'h0010, 8'h00, stalls, wes, rvs, rd);
    $display("cpu read addr 0010: stalls %0d rvalids %0d data %h", stalls, rvs, rd);
    n_checks++;
    if (stalls !== 2) $display("FAIL rd_stall: got %0d required 2", stalls); else n_pass++;
    n_checks++;
    if (wes !== 0) $display("FAIL rd_mem_we: got %0d required 0", wes); else n_pass++;
    n_checks++;
    if (rvs !== 1) $display("FAIL rd_rvalid: got %0d required 1", rvs); else n_pass++;
    n_checks++;
    if (rd !== 8'hA5) $display("FAIL rd_data: got %h required a5", rd); else n_pass++;
  endtask

  task automatic test_disp_burst(input logic [15:0] base);
    logic [15:0] exp_a;
    disp_req = 1'b1; disp_base = base;
    capture(20, 1'b0);
    $display("burst base %h: gnt %0d reads %0d rvalids %0d done %0d at %0d",
             base, n_gnt, n_rd, n_rv, n_done, done_cyc);
    n_checks++;
    if (n_gnt !== 1 || gnt_cyc0 !== 0)
      $display("FAIL burst_gnt: got %0d pulses first at %0d required 1 at 0", n_gnt, gnt_cyc0);
    else n_pass++;
    n_checks++;
    if (n_rd !== 16) $display("FAIL burst_reads: got %0d required 16", n_rd); else n_pass++;
    for (int k = 0; k < 16 && k < n_rd; k++) begin
      exp_a = base + 16'(k);
      n_checks++;
      if (rd_addr[k] !== exp_a || rd_cyc[k] !== k + 1)
        $display("FAIL burst_addr[%0d]: got %h at cycle %0d required %h at %0d",
                 k, rd_addr[k], rd_cyc[k], exp_a, k + 1);
      else n_pass++;
    end
    n_checks++;
    if (n_rv !== 16) $display("FAIL burst_rvalids: got %0d required 16", n_rv); else n_pass++;
    for (int k = 0; k < 16 && k < n_rv; k++) begin
      exp_a = base + 16'(k);
      n_checks++;
      if (rv_data[k] !== init_val(exp_a) || rv_cyc[k] !== k + 2)
        $display("FAIL burst_rdata[%0d]: got %h at cycle %0d required %h at %0d",
                 k, rv_data[k], rv_cyc[k], init_val(exp_a), k + 2);
      else n_pass++;
    end
    n_checks++;
    if (n_done !== 1 || done_cyc !== 17)
      $display("FAIL burst_done: got %0d pulses first at %0d required 1 at 17", n_done, done_cyc);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit seen;
    pulse_reset();
    disp_req = 1'b1; disp_base = 16'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    capture(24, 1'b1);
    $display("simultaneous: first gnt %0d gnts %0d cpu stall %0d cpu rvalid at %0d data %h",
             gnt_cyc0, n_gnt, n_stall, cpu_rv_cyc, cpu_rv_data);
    n_checks++;
    if (gnt_cyc0 !== 0) $display("FAIL sim_disp_first: got %0d required 0", gnt_cyc0); else n_pass++;
    n_checks++;
    if (n_stall !== 19) $display("FAIL sim_stall: got %0d required 19", n_stall); else n_pass++;
    n_checks++;
    if (n_rd < 17 || rd_addr[16] !== 16'h0020 || rd_cyc[16] !== 18)
      $display("FAIL sim_cpu_issue: got %0d reads, 17th %h at %0d required 0020 at 18",
               n_rd, rd_addr[16], rd_cyc[16]);
    else n_pass++;
    n_checks++;
    if (n_cpu_rv !== 1 || cpu_rv_cyc !== 19 || cpu_rv_data !== init_val(16'h0020))
      $display("FAIL sim_cpu_rdata: got %0d rvalids at %0d data %h required 1 at 19 data %h",
               n_cpu_rv, cpu_rv_cyc, cpu_rv_data, init_val(16'h0020));
    else n_pass++;
    n_checks++;
    if (n_done !== 1 || done_cyc !== 17)
      $display("FAIL sim_done: got %0d at %0d required 1 at 17", n_done, done_cyc);
    else n_pass++;
    n_checks++;
    if (n_gnt !== 2) $display("FAIL sim_regrant: got %0d grants required 2", n_gnt); else n_pass++;
`ifdef PIX_ARB_STATS_EN
    n_checks++;
    if (cpu_wait_cnt !== 16'd17) $display("FAIL sim_wait_cnt: got %0d required 17", cpu_wait_cnt);
    else n_pass++;
`endif
    disp_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (disp_done_o) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!seen) $display("FAIL sim_second_done: got none within 40 cycles required 1"); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int stalls, wes, rvs;
    logic [7:0] rd;
    disp_req = 1'b1; disp_base = 16'h0300;
    @(negedge clk);
    disp_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (!mem_en_o || mem_addr_o !== 16'h0305)
      $display("FAIL mid_cnt5: got en %b addr %h required 1 0305", mem_en_o, mem_addr_o);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (all_outs !== 47'd0) $display("FAIL mid_async_outs: got %h required 0", all_outs);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (all_outs !== 47'd0) $display("FAIL mid_edge_outs: got %h required 0", all_outs);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    capture(20, 1'b0);
    $display("reset mid burst: later reads %0d rvalids %0d done %0d", n_rd, n_rv, n_done);
    n_checks++;
    if (n_rd !== 0 || n_rv !== 0 || n_done !== 0)
      $display("FAIL mid_abandon: got reads %0d rvalids %0d done %0d required 0 0 0",
               n_rd, n_rv, n_done);
    else n_pass++;
    cpu_access(1'b0, 16'h0005, 8'h00, stalls, wes, rvs, rd);
    $display("cpu read addr 0005 after reset: stalls %0d data %h", stalls, rd);
    n_checks++;
    if (stalls !== 2 || rvs !== 1 || rd !== init_val(16'h0005))
      $display("FAIL mid_restart: got stalls %0d rvalids %0d data %h required 2 1 %h",
               stalls, rvs, rd, init_val(16'h0005));
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 1'b0; disp_base = '0;
    @(negedge clk);
    test_reset();
    test_cpu_write_read();
    test_disp_burst(16'h0100);
    test_disp_burst(16'hFFF8);
    test_simultaneous();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns required finish");
    $fatal(1);
  end

endmodule
